// File: rtl/scene_click_if.sv
// Mouse, region-table and engine-flag inputs plus scene/click outputs of the UI front end.
// Latency: none; this is a wiring bundle.
// Backpressure: none; all signals are levels or single-cycle pulses.
interface scene_click_if #(
  parameter int N_REGIONS  = 10,
  parameter int COORD_W    = 10,
  parameter int NUM_LEVELS = 3
);
  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  logic [COORD_W-1:0]           mouse_x;
  logic [COORD_W-1:0]           mouse_y;
  logic                         mouse_l;
  logic [N_REGIONS*COORD_W-1:0] reg_x0;
  logic [N_REGIONS*COORD_W-1:0] reg_x1;
  logic [N_REGIONS*COORD_W-1:0] reg_y0;
  logic [N_REGIONS*COORD_W-1:0] reg_y1;
  logic [N_REGIONS-1:0]         reg_en;
  logic                         game_win;
  logic                         game_lose;
  logic [2:0]                   scene;
  logic [LVL_W-1:0]             level;
  logic                         game_init;
  logic [N_REGIONS-1:0]         hover;
  logic [N_REGIONS-1:0]         click;
  logic                         click_valid;
  logic [IDX_W-1:0]             click_idx;

  // Environment side: mouse controller, region tables and game engine
  modport master (
    output mouse_x, mouse_y, mouse_l, reg_x0, reg_x1, reg_y0, reg_y1, reg_en,
    output game_win, game_lose,
    input  scene, level, game_init, hover, click, click_valid, click_idx
  );

  // Controller side
  modport slave (
    input  mouse_x, mouse_y, mouse_l, reg_x0, reg_x1, reg_y0, reg_y1, reg_en,
    input  game_win, game_lose,
    output scene, level, game_init, hover, click, click_valid, click_idx
  );
endinterface

// File: rtl/scene_click_controller.sv
// Region hit-test, armed/hold-off click detector and START/MENU/PLAY/WIN/LOSE scene FSM.
// Latency: hover, click pulses, scene, level and game_init all appear 1 cycle after their cause.
// Backpressure: none; clicks are fire-and-forget single-cycle pulses.
module scene_click_controller #(
  parameter int N_REGIONS   = 10,
  parameter int COORD_W     = 10,
  parameter int NUM_LEVELS  = 3,
  parameter int HOLDOFF_CYC = 1024
) (
  input logic         clk,
  input logic         rst,
  scene_click_if.slave bus
);
  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int HO_W  = $clog2(HOLDOFF_CYC + 1);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_MENU  = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } scene_t;

  scene_t               scene_q;
  scene_t               scene_nxt;
  logic [LVL_W-1:0]     level_q;
  logic                 game_init_q;
  logic                 go_play;
  logic [N_REGIONS-1:0] hit;
  logic [N_REGIONS-1:0] cand;
  logic [N_REGIONS-1:0] hover_q;
  logic [N_REGIONS-1:0] click_q;
  logic                 click_valid_q;
  logic [IDX_W-1:0]     click_idx_q;
  logic [IDX_W-1:0]     win_idx;
  logic                 l_q;
  logic                 armed_q;
  logic [HO_W-1:0]      holdoff_q;
  logic                 rise;
  logic                 acc;
  logic                 scene_chg;
  logic                 is_lvl;

  // Half-open rectangle test per region; inverted bounds naturally yield an empty region
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      hit[i] = (bus.mouse_x >= bus.reg_x0[i*COORD_W +: COORD_W]) &&
               (bus.mouse_x <  bus.reg_x1[i*COORD_W +: COORD_W]) &&
               (bus.mouse_y >= bus.reg_y0[i*COORD_W +: COORD_W]) &&
               (bus.mouse_y <  bus.reg_y1[i*COORD_W +: COORD_W]);
    end
  end

  assign cand = hit & bus.reg_en;

  // Lowest enabled hit wins: scan downwards so the last write is the lowest index
  always_comb begin
    win_idx = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDX_W'(i);
    end
  end

  assign rise   = bus.mouse_l & ~l_q;
  assign acc    = rise & armed_q & (holdoff_q == '0) & (|cand);
  assign is_lvl = ({1'b0, win_idx} < (IDX_W + 1)'(NUM_LEVELS));

  // Scene transition decode; an accepted click is judged against the current scene
  always_comb begin
    scene_nxt = scene_q;
    go_play   = 1'b0;
    case (scene_q)
      S_START: if (acc && win_idx == '0) scene_nxt = S_MENU;
      S_MENU: begin
        if (acc && is_lvl) begin
          scene_nxt = S_PLAY;
          go_play   = 1'b1;
        end
      end
      S_PLAY: begin
        if (bus.game_win)       scene_nxt = S_WIN;
        else if (bus.game_lose) scene_nxt = S_LOSE;
      end
      S_WIN, S_LOSE: if (acc && win_idx == '0) scene_nxt = S_MENU;
      default: scene_nxt = S_START;
    endcase
  end

  assign scene_chg = (scene_nxt != scene_q);

  // Scene state, level latch and game_init pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scene_q     <= S_START;
      level_q     <= '0;
      game_init_q <= 1'b0;
    end else begin
      scene_q     <= scene_nxt;
      game_init_q <= go_play;
      if (go_play) level_q <= win_idx[LVL_W-1:0];
    end
  end

  // Button edge history, re-arm on release, hold-off after each scene change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_q       <= 1'b0;
      armed_q   <= 1'b0;
      holdoff_q <= '0;
    end else begin
      l_q <= bus.mouse_l;
      if (scene_chg)         armed_q <= 1'b0;
      else if (!bus.mouse_l) armed_q <= 1'b1;
      if (scene_chg)              holdoff_q <= HO_W'(HOLDOFF_CYC);
      else if (holdoff_q != '0)   holdoff_q <= holdoff_q - HO_W'(1);
    end
  end

  // Registered click outputs; per-region pulses only while playing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      click_valid_q <= 1'b0;
      click_q       <= '0;
      click_idx_q   <= '0;
    end else begin
      click_valid_q <= acc;
      click_q       <= (acc && scene_q == S_PLAY) ? (N_REGIONS'(1) << win_idx) : '0;
      if (acc) click_idx_q <= win_idx;
    end
  end

  // Hover is a plain registered copy of the geometric hit, independent of reg_en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hover_q <= '0;
    else      hover_q <= hit;
  end

  assign bus.scene       = scene_q;
  assign bus.level       = level_q;
  assign bus.game_init   = game_init_q;
  assign bus.hover       = hover_q;
  assign bus.click       = click_q;
  assign bus.click_valid = click_valid_q;
  assign bus.click_idx   = click_idx_q;
endmodule

// File: tb/tb_scene_click_controller.sv
// Directed bench for scene_click_controller with a short hold-off.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: not applicable.
module tb_scene_click_controller;
  localparam int N   = 10;
  localparam int CW  = 10;
  localparam int NL  = 3;
  localparam int HO  = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic seen;

  scene_click_if #(.N_REGIONS(N), .COORD_W(CW), .NUM_LEVELS(NL)) bus ();

  scene_click_controller #(
    .N_REGIONS(N), .COORD_W(CW), .NUM_LEVELS(NL), .HOLDOFF_CYC(HO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_region(input int i, input int x0, input int x1, input int y0, input int y1);
    bus.reg_x0[i*CW +: CW] = CW'(x0);
    bus.reg_x1[i*CW +: CW] = CW'(x1);
    bus.reg_y0[i*CW +: CW] = CW'(y0);
    bus.reg_y1[i*CW +: CW] = CW'(y1);
  endtask

  task automatic move(input int x, input int y);
    bus.mouse_x = CW'(x);
    bus.mouse_y = CW'(y);
  endtask

  // release for one cycle, then press; returns just after the rise is evaluated
  task automatic press();
    bus.mouse_l = 1'b0;
    step();
    bus.mouse_l = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.mouse_l   = 1'b1;
    bus.game_win  = 1'b0;
    bus.game_lose = 1'b0;
    bus.reg_x0 = '0;
    bus.reg_x1 = '0;
    bus.reg_y0 = '0;
    bus.reg_y1 = '0;
    bus.reg_en = '1;
    set_region(0,   0, 100,   0, 100);
    set_region(1, 100, 200,   0, 100);
    set_region(2, 200, 300, 100, 200);
    set_region(3, 400, 500,   0, 100);
    set_region(4, 100, 100, 300, 400);
    set_region(5, 250, 350, 150, 250);
    set_region(6, 600, 640, 300, 400);
    move(50, 50);

    // reset state with button held
    step();
    step();
    chk("rst_scene", 32'(bus.scene), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_hover", 32'(bus.hover), 32'd0);
    chk("rst_click_valid", 32'(bus.click_valid), 32'd0);
    chk("rst_click_idx", 32'(bus.click_idx), 32'd0);
    chk("rst_game_init", 32'(bus.game_init), 32'd0);

    // press held through reset must not click
    rst = 1'b1;
    step();
    chk("held_hover", 32'(bus.hover), 32'h001);
    chk("held_no_click", 32'(bus.click_valid), 32'd0);
    step();
    chk("held_scene", 32'(bus.scene), 32'd0);

    // release and press region 0 at START
    press();
    chk("start_valid", 32'(bus.click_valid), 32'd1);
    chk("start_idx", 32'(bus.click_idx), 32'd0);
    chk("start_click", 32'(bus.click), 32'd0);
    chk("start_to_menu", 32'(bus.scene), 32'd1);

    // MENU: press at cycle 10 is inside hold-off; engine flags ignored here
    bus.mouse_l = 1'b0;
    bus.game_win = 1'b1;
    move(150, 50);
    repeat (10) step();
    bus.mouse_l = 1'b1;
    step();
    chk("holdoff_no_click", 32'(bus.click_valid), 32'd0);
    chk("menu_ignores_win", 32'(bus.scene), 32'd1);
    bus.mouse_l = 1'b0;
    repeat (8) step();
    bus.game_win = 1'b0;
    step();
    bus.mouse_l = 1'b1;
    step();
    chk("menu_valid", 32'(bus.click_valid), 32'd1);
    chk("menu_idx", 32'(bus.click_idx), 32'd1);
    chk("menu_to_play", 32'(bus.scene), 32'd2);
    chk("play_level", 32'(bus.level), 32'd1);
    chk("game_init_pulse", 32'(bus.game_init), 32'd1);
    chk("menu_click_zero", 32'(bus.click), 32'd0);

    // button held across MENU->PLAY over region 3: no click-through
    move(450, 50);
    step();
    chk("game_init_one_cycle", 32'(bus.game_init), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen = seen | bus.click_valid | (|bus.click);
    end
    chk("held_across_change", 32'(seen), 32'd0);
    press();
    chk("play_click3", 32'(bus.click), 32'h008);
    chk("play_idx3", 32'(bus.click_idx), 32'd3);
    step();
    chk("click3_single", 32'(bus.click), 32'd0);

    // overlapping regions 2 and 5
    move(260, 160);
    bus.mouse_l = 1'b0;
    step();
    chk("overlap_hover", 32'(bus.hover), 32'h024);
    press();
    chk("overlap_idx2", 32'(bus.click_idx), 32'd2);
    chk("overlap_click2", 32'(bus.click), 32'h004);
    bus.reg_en[2] = 1'b0;
    press();
    chk("overlap_idx5", 32'(bus.click_idx), 32'd5);
    chk("overlap_click5", 32'(bus.click), 32'h020);
    bus.reg_en[5] = 1'b0;
    press();
    chk("both_disabled", 32'(bus.click_valid), 32'd0);
    chk("idx_holds", 32'(bus.click_idx), 32'd5);
    bus.reg_en = '1;
    bus.mouse_l = 1'b0;

    // empty and exclusive-edge regions
    move(100, 350);
    step();
    chk("empty_region", 32'(bus.hover), 32'd0);
    move(639, 350);
    step();
    chk("edge_inside", 32'(bus.hover), 32'h040);
    move(640, 350);
    step();
    chk("edge_excl", 32'(bus.hover), 32'd0);

    // win beats lose; then back to MENU with level held
    bus.game_win  = 1'b1;
    bus.game_lose = 1'b1;
    step();
    chk("win_priority", 32'(bus.scene), 32'd3);
    bus.game_win  = 1'b0;
    bus.game_lose = 1'b0;
    move(50, 50);
    repeat (HO + 1) step();
    bus.mouse_l = 1'b1;
    step();
    chk("win_to_menu", 32'(bus.scene), 32'd1);
    chk("win_valid", 32'(bus.click_valid), 32'd1);
    chk("win_click_zero", 32'(bus.click), 32'd0);
    chk("level_held", 32'(bus.level), 32'd1);

    // enter PLAY at level 2, then async reset between edges
    move(210, 110);
    bus.mouse_l = 1'b0;
    repeat (HO + 1) step();
    bus.mouse_l = 1'b1;
    step();
    chk("play2_scene", 32'(bus.scene), 32'd2);
    chk("play2_level", 32'(bus.level), 32'd2);
    step();
    chk("play2_hover", 32'(bus.hover), 32'h004);
    #5;
    rst = 1'b0;
    #1;
    chk("arst_scene", 32'(bus.scene), 32'd0);
    chk("arst_level", 32'(bus.level), 32'd0);
    chk("arst_hover", 32'(bus.hover), 32'd0);
    chk("arst_click_idx", 32'(bus.click_idx), 32'd0);
    chk("arst_click_valid", 32'(bus.click_valid), 32'd0);
    chk("arst_click", 32'(bus.click), 32'd0);
    chk("arst_game_init", 32'(bus.game_init), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
